// File: rtl/cmd_tree_scheduler_pkg.sv
// Shared definitions for the command-tree scheduler.
//   sched_state_e  : scheduler FSM encoding (RUN / DRAIN / STOPPED)
//   tree_latency() : cycles from an o_en/o_cmd sample to the leaf outputs
//   leaf_cnt_width(): width of a per-leaf reservation counter
package cmd_tree_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_STOPPED = 2'd2
  } sched_state_e;

  // One register stage per tree level plus the root register.
  function automatic int tree_latency(input int num_leaves);
    return $clog2(num_leaves) + 1;
  endfunction

  // The counter must hold the value tl + hold.
  function automatic int leaf_cnt_width(input int tl, input int hold);
    return $clog2(tl + hold + 1);
  endfunction

endpackage

// File: rtl/cmd_tree_scheduler_if.sv
// Bundle of request handshake and tree-drive signals for cmd_tree_scheduler.
// Handshake: a request from requester r is accepted at the rising CLK edge
// where i_req_valid[r] & o_req_ready[r] are both high; o_req_ready is
// combinational and at most one-hot. A requester holds valid and mask stable
// until accepted (or withdraws it freely; nothing is latched before accept).
//   master : requester / environment side (drives i_*)
//   slave  : scheduler side (drives o_* and dbg_state)
interface cmd_tree_scheduler_if
  import cmd_tree_scheduler_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int NUM_OUTPUT_DATA = 8
);
  logic [NUM_REQ-1:0]                 i_req_valid;
  logic [NUM_REQ*NUM_OUTPUT_DATA-1:0] i_req_mask;
  logic [NUM_REQ-1:0]                 o_req_ready;
  logic                               i_stop;
  logic                               o_en;
  logic [NUM_OUTPUT_DATA-1:0]         o_cmd;
  logic [$clog2(NUM_REQ)-1:0]         o_grant_id;
  logic                               o_delivered;
  logic [NUM_OUTPUT_DATA-1:0]         o_leaf_busy;
  logic                               o_zero_err;
  logic                               o_stopped;
  sched_state_e                       dbg_state;

  modport master (
    output i_req_valid, i_req_mask, i_stop,
    input  o_req_ready, o_en, o_cmd, o_grant_id, o_delivered,
           o_leaf_busy, o_zero_err, o_stopped, dbg_state
  );

  modport slave (
    input  i_req_valid, i_req_mask, i_stop,
    output o_req_ready, o_en, o_cmd, o_grant_id, o_delivered,
           o_leaf_busy, o_zero_err, o_stopped, dbg_state
  );
endinterface

// File: rtl/cmd_tree_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector (already qualified for eligibility)
//   ptr_i   : highest-priority index this cycle
//   grant_o : one-hot grant, zero when no request
//   idx_o   : index of the granted requester (0 when no request)
module cmd_tree_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);
  localparam int IW = $clog2(NUM_REQ);

  logic          found;
  logic [IW-1:0] cand;

  // Scan from the pointer; NUM_REQ is a power of two so the index wraps
  // naturally in IW bits.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr_i + IW'(i);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
  end
endmodule

// File: rtl/cmd_tree_scheduler.sv
// Round-robin scheduler feeding a registered binary command-distribution tree.
//   CLK, rst : clock and synchronous active-high reset
//   bus      : slave side of cmd_tree_scheduler_if
//     i_req_valid/i_req_mask/o_req_ready : per-requester request handshake
//     i_stop      : level request to drain in-flight work and halt
//     o_en/o_cmd/o_grant_id : registered tree drive
//     o_delivered : command at the leaves (TREE_LATENCY after o_en)
//     o_leaf_busy : per-leaf reservation
//     o_zero_err  : zero-mask request accepted and dropped
//     o_stopped   : scheduler halted
//     dbg_state   : current FSM state
module cmd_tree_scheduler
  import cmd_tree_scheduler_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int HOLD_CYCLES     = 2
) (
  input  logic           CLK,
  input  logic           rst,
  cmd_tree_scheduler_if.slave bus
);
  localparam int TREE_LATENCY = tree_latency(NUM_OUTPUT_DATA);
  localparam int CW           = leaf_cnt_width(TREE_LATENCY, HOLD_CYCLES);
  localparam int IW           = $clog2(NUM_REQ);
  localparam logic [CW-1:0] LEAF_LOAD = CW'(TREE_LATENCY + HOLD_CYCLES);

  sched_state_e                state_q;
  logic                        stopped_q;
  logic [IW-1:0]               ptr_q;
  logic [IW-1:0]               gid_q;
  logic                        en_q;
  logic                        zero_err_q;
  logic [NUM_OUTPUT_DATA-1:0]  cmd_q;
  logic [CW-1:0]               cnt_q [NUM_OUTPUT_DATA];
  logic [TREE_LATENCY-1:0]     flight_q;

  logic [NUM_OUTPUT_DATA-1:0]  leaf_busy;
  logic [NUM_OUTPUT_DATA-1:0]  sel_mask;
  logic [NUM_REQ-1:0]          eligible;
  logic [NUM_REQ-1:0]          arb_grant;
  logic [NUM_REQ-1:0]          ready;
  logic [IW-1:0]               arb_idx;
  logic                        grant_en;
  logic                        accept;
  logic                        drain_idle;

  always_comb begin
    leaf_busy = '0;
    for (int k = 0; k < NUM_OUTPUT_DATA; k++) begin
      leaf_busy[k] = (cnt_q[k] != '0);
    end
  end

  // A request is eligible only if none of its leaves is reserved; a zero
  // mask therefore always qualifies and is dropped on accept.
  always_comb begin
    eligible = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      eligible[r] = bus.i_req_valid[r] &&
        ((bus.i_req_mask[r*NUM_OUTPUT_DATA +: NUM_OUTPUT_DATA] & leaf_busy) == '0);
    end
  end

  cmd_tree_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  // Grants only while running with no stop pending; the RUN->DRAIN
  // transition cycle therefore never grants.
  always_comb begin
    grant_en = (state_q == ST_RUN) && !bus.i_stop && !rst;
    ready    = grant_en ? arb_grant : '0;
    accept   = |ready;
    sel_mask = bus.i_req_mask[int'(arb_idx)*NUM_OUTPUT_DATA +: NUM_OUTPUT_DATA];
  end

  assign drain_idle = (flight_q == '0) && (leaf_busy == '0) && !en_q;

  // Scheduler FSM
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= ST_RUN;
      stopped_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          stopped_q <= 1'b0;
          if (bus.i_stop) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.i_stop) begin
            state_q   <= ST_RUN;
            stopped_q <= 1'b0;
          end else if (drain_idle) begin
            state_q   <= ST_STOPPED;
            stopped_q <= 1'b1;
          end
        end
        ST_STOPPED: begin
          if (!bus.i_stop) begin
            state_q   <= ST_RUN;
            stopped_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          stopped_q <= 1'b0;
        end
      endcase
    end
  end

  // Issue path, leaf reservations and in-flight tracking
  always_ff @(posedge CLK) begin
    if (rst) begin
      en_q       <= 1'b0;
      cmd_q      <= '0;
      gid_q      <= '0;
      zero_err_q <= 1'b0;
      ptr_q      <= '0;
      flight_q   <= '0;
      for (int k = 0; k < NUM_OUTPUT_DATA; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      en_q       <= 1'b0;
      cmd_q      <= '0;
      zero_err_q <= 1'b0;
      // o_delivered is the tail of this shift of o_en.
      flight_q   <= {flight_q[TREE_LATENCY-2:0], en_q};

      for (int k = 0; k < NUM_OUTPUT_DATA; k++) begin
        if (accept && sel_mask[k]) begin
          cnt_q[k] <= LEAF_LOAD;
        end else if (cnt_q[k] != '0) begin
          cnt_q[k] <= cnt_q[k] - 1'b1;
        end
      end

      if (accept) begin
        ptr_q <= arb_idx + 1'b1;
        if (sel_mask != '0) begin
          en_q  <= 1'b1;
          cmd_q <= sel_mask;
          gid_q <= arb_idx;
        end else begin
          zero_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_en        = en_q;
  assign bus.o_cmd       = cmd_q;
  assign bus.o_grant_id  = gid_q;
  assign bus.o_delivered = flight_q[TREE_LATENCY-1];
  assign bus.o_leaf_busy = leaf_busy;
  assign bus.o_zero_err  = zero_err_q;
  assign bus.o_stopped   = stopped_q;
  assign bus.dbg_state   = state_q;

endmodule
